// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core.
// Ciphertext and key are captured in IDLE, run through IP, 16 Feistel rounds
// with subkeys K16..K1 (RPC rounds per clock), a final swap and inv_IP.
// Subkeys are produced on the fly by a right-rotating key schedule that starts
// from PC1(key), which is both C0D0 and C16D16.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready is high only in IDLE
//   key                  64-bit DES key (parity bits ignored)
//   data_in              64-bit ciphertext block
//   out_valid/out_ready  output handshake
//   data_out             64-bit plaintext, held while out_valid && !out_ready
module des_decrypt_iter #(
  parameter int unsigned RPC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] key,
  input  logic [63:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("des_decrypt_iter: RPC must be 1, 2, 4, 8 or 16");
  end

  // Tables use DES numbering: bit 1 is the MSB of the source vector.
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned IPINV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
  // Indexed by {box[2:0], row[1:0], col[3:0]}.
  localparam logic [3:0] SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] inv_ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IPINV_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    x = '0;
    for (int unsigned i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
    x = x ^ k;
    s = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      six = x[47:42];
      x   = x << 6;
      s   = {s[27:0], SBOX[{3'(b), six[5], six[0], six[4:1]}]};
    end
    y = '0;
    for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_round(input logic [63:0] lr, input logic [47:0] k);
    return {lr[31:0], lr[63:32] ^ f_func(lr[31:0], k)};
  endfunction

  // The rotation before round r undoes the encryption left shift of round r+1,
  // so single-bit steps fall before rounds 15, 8 and 1.
  function automatic logic [1:0] rot_amount(input logic [4:0] r);
    if (r == 5'd16) return 2'd0;
    if (r == 5'd15 || r == 5'd8 || r == 5'd1) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [55:0] cd_rotr(input logic [55:0] cd, input logic [1:0] s);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    case (s)
      2'd1:    begin c = {c[0], c[27:1]};   d = {d[0], d[27:1]};   end
      2'd2:    begin c = {c[1:0], c[27:2]}; d = {d[1:0], d[27:2]}; end
      default: ;
    endcase
    return {c, d};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [63:0] lr;        // {L, R}
  logic [55:0] cd;        // {C, D}
  logic [4:0]  cnt;
  logic [63:0] lr_n;
  logic [55:0] cd_n;
  logic [4:0]  rnd;
  logic [4:0]  cnt_step;
  logic        cnt_bad;

  always_comb begin
    lr_n = lr;
    cd_n = cd;
    rnd  = '0;
    for (int unsigned k = 0; k < RPC; k++) begin
      rnd  = 5'(5'd16 - cnt - 5'(k));
      cd_n = cd_rotr(cd_n, rot_amount(rnd));
      lr_n = des_round(lr_n, pc2_perm(cd_n));
    end
    cnt_step = cnt + 5'(RPC);
    cnt_bad  = (cnt >= 5'd16) || ((cnt & 5'(RPC - 1)) != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      cnt       <= '0;
      lr        <= '0;
      cd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            lr       <= ip_perm(data_in);
            cd       <= pc1_perm(key);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt_bad) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            lr  <= lr_n;
            cd  <= cd_n;
            cnt <= cnt_step;
            if (cnt_step == 5'd16) begin
              data_out  <= inv_ip_perm({lr_n[31:0], lr_n[63:32]});
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
module tb_des_decrypt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] key;
  logic [63:0] data_in;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [63:0] dout [4];

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];
  int lat_of [4] = '{16, 8, 4, 1};

  localparam logic [63:0] K2 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C2 = 64'h85E813540F0AB405;
  localparam logic [63:0] P2 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K3 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P3 = 64'h8787878787878787;

  des_decrypt_iter #(.RPC(1)) u_rpc1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .key(key), .data_in(data_in), .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]));
  des_decrypt_iter #(.RPC(2)) u_rpc2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .key(key), .data_in(data_in), .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]));
  des_decrypt_iter #(.RPC(4)) u_rpc4 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .key(key), .data_in(data_in), .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout[2]));
  des_decrypt_iter #(.RPC(16)) u_rpc16 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .key(key), .data_in(data_in), .out_valid(ov[3]), .out_ready(ordy[3]), .data_out(dout[3]));

  // Reference encryption model (forward key schedule).
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // DES bit n (1 = MSB) of a w-bit value held right-aligned in x.
  function automatic logic sel(input logic [63:0] x, input int w, input int n);
    return x[6'(w - n)];
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    int          row;
    int          col;
    e = '0;
    for (int i = 0; i < 48; i++) e = {e[46:0], sel({32'b0, r}, 32, E_T[i])};
    e = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = 6'(e >> (42 - 6 * b));
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s = {s[27:0], 4'(SB[b * 64 + row * 16 + col])};
    end
    p = '0;
    for (int i = 0; i < 32; i++) p = {p[30:0], sel({32'b0, s}, 32, P_T[i])};
    return p;
  endfunction

  function automatic logic [63:0] des_enc(input logic [63:0] k, input logic [63:0] pt);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] sk;
    logic [63:0] x;
    logic [63:0] y;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    int          sh;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = {cd[54:0], sel(k, 64, PC1_T[i])};
    c = cd[55:28];
    d = cd[27:0];
    x = '0;
    for (int i = 0; i < 64; i++) x = {x[62:0], sel(pt, 64, IP_T[i])};
    l = x[63:32];
    r = x[31:0];
    for (int i = 1; i <= 16; i++) begin
      sh = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
      for (int j = 0; j < sh; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      sk = '0;
      for (int n = 0; n < 48; n++) sk = {sk[46:0], sel({8'b0, c, d}, 56, PC2_T[n])};
      t = r;
      r = l ^ m_f(r, sk);
      l = t;
    end
    x = {r, l};
    // Inverse IP: output bit IP_T[i] takes input bit i+1.
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(64 - IP_T[i])] = x[6'(63 - i)];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic accept_block(input int d, input logic [63:0] k, input logic [63:0] ct,
                              input logic [63:0] pt);
    int n;
    n = 0;
    while (ir[d] !== 1'b1 && n < 50) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk($sformatf("in_ready_before_accept_d%0d", d), 64'(ir[d]), 64'd1);
    key = k;
    data_in = ct;
    iv[d] = 1'b1;
    sb.push_back(pt);
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic finish_block(input int d, input int exp_lat, input bit release_out);
    int lat;
    logic [63:0] e;
    lat = 0;
    while (ov[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk($sformatf("out_valid_seen_d%0d", d), 64'(ov[d]), 64'd1);
    chk($sformatf("latency_d%0d", d), 64'(lat), 64'(exp_lat));
    e = '1;
    if (sb.size() > 0) e = sb.pop_front();
    else chk("scoreboard_empty", 64'(sb.size()), 64'd1);
    chk($sformatf("plaintext_d%0d", d), dout[d], e);
    if (release_out) begin
      ordy[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy[d] = 1'b0;
      chk($sformatf("out_valid_drop_d%0d", d), 64'(ov[d]), 64'd0);
      chk($sformatf("in_ready_after_d%0d", d), 64'(ir[d]), 64'd1);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k;
    logic [63:0] pt;
    logic [63:0] blk;
    bit          seen;

    // Reset and initial values
    rst_n = 1'b0; iv = '0; ordy = '0; key = '0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_out_valid_d%0d", d), 64'(ov[d]), 64'd0);
      chk($sformatf("reset_data_out_d%0d", d), dout[d], 64'd0);
      chk($sformatf("reset_in_ready_d%0d", d), 64'(ir[d]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) chk($sformatf("release_in_ready_d%0d", d), 64'(ir[d]), 64'd1);

    // Known-answer test, RPC=1
    accept_block(0, K2, C2, P2);
    finish_block(0, 16, 1'b1);

    // Second KAT on every RPC variant
    for (int d = 0; d < 4; d++) begin
      accept_block(d, K3, 64'd0, P3);
      finish_block(d, lat_of[d], 1'b1);
    end

    // Backpressure: output held, in_valid ignored
    accept_block(0, K2, C2, P2);
    finish_block(0, 16, 1'b0);
    for (int i = 0; i < 10; i++) begin
      iv[0] = i[0];
      data_in = ~data_in;
      @(posedge clk);
      @(negedge clk);
      chk("hold_data_out", dout[0], P2);
      chk("hold_in_ready", 64'(ir[0]), 64'd0);
      chk("hold_out_valid", 64'(ov[0]), 64'd1);
    end
    // in_valid together with out_ready in DONE: only the output handshake happens
    iv[0] = 1'b1; ordy[0] = 1'b1; key = K3; data_in = 64'd0;
    sb.push_back(P3);
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("simul_out_valid", 64'(ov[0]), 64'd0);
    chk("simul_in_ready", 64'(ir[0]), 64'd1);
    chk("simul_data_kept", dout[0], P2);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    chk("simul_accept_next", 64'(ir[0]), 64'd0);
    finish_block(0, 16, 1'b1);

    // Inputs changed mid-run have no effect
    accept_block(0, K2, C2, P2);
    key = ~K2; data_in = ~C2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    key = 64'hDEADBEEFCAFEF00D; data_in = 64'h0;
    finish_block(0, 13, 1'b1);

    // Reset at round 7 aborts the block
    accept_block(0, K3, 64'd0, P3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", 64'(ov[0]), 64'd0);
    chk("abort_in_ready", 64'(ir[0]), 64'd0);
    chk("abort_data_out", dout[0], 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (ov[0] === 1'b1) seen = 1'b1;
    end
    chk("abort_no_output", 64'(seen), 64'd0);
    chk("abort_ready_again", 64'(ir[0]), 64'd1);
    accept_block(0, K2, C2, P2);
    finish_block(0, 16, 1'b1);

    // Round trip against the reference encryption
    for (int i = 0; i < 20; i++) begin
      k  = {$urandom, $urandom};
      pt = {$urandom, $urandom};
      accept_block(i % 4, k, des_enc(k, pt), pt);
      finish_block(i % 4, lat_of[i % 4], 1'b1);
    end
    blk = P2;
    for (int i = 0; i < 16; i++) begin
      blk = {blk[59:0], blk[63:60]};
      accept_block(i % 4, K2, des_enc(K2, blk), blk);
      finish_block(i % 4, lat_of[i % 4], 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
